// File: rtl/poli_crc_engine.sv
`default_nettype none
// ============================================================================
// Module      : poli_crc_engine
// Description : CRC-32 datapath for POLI; MSB-first, non-reflected, no final
//               XOR, BITS_PER_CYCLE input bits folded in per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module poli_crc_engine #(
  parameter int                   WORD_SIZE      = 32,
  parameter logic [WORD_SIZE-1:0] INIT_VALUE     = 32'hFFFF_FFFF,
  parameter int                   BITS_PER_CYCLE = 1
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 crc_init,
  input  logic [WORD_SIZE-1:0] crc_poly,
  input  logic                 data_wen,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] crc_out,
  output logic [WORD_SIZE-1:0] crc_status
);

  localparam int                 c_N        = WORD_SIZE / BITS_PER_CYCLE;
  localparam int                 c_CNT_W    = (c_N > 1) ? $clog2(c_N) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_N - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [WORD_SIZE-1:0]   r_crc;
  logic [WORD_SIZE-1:0]   w_crc_nxt;
  logic [WORD_SIZE-1:0]   r_shift;
  logic [WORD_SIZE-1:0]   w_shift_nxt;
  logic [WORD_SIZE-1:0]   r_poly;
  logic [WORD_SIZE-1:0]   w_poly_nxt;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_CNT_W-1:0]     w_cnt_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_ovr;
  logic                   w_ovr_nxt;
  logic [WORD_SIZE-1:0]   w_crc_step;
  logic [WORD_SIZE-1:0]   w_shift_step;

  // Bits are folded in serially so any BITS_PER_CYCLE gives the same result.
  always_comb begin : p_step
    w_crc_step   = r_crc;
    w_shift_step = r_shift;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (w_crc_step[WORD_SIZE-1] ^ w_shift_step[WORD_SIZE-1]) begin
        w_crc_step = {w_crc_step[WORD_SIZE-2:0], 1'b0} ^ r_poly;
      end else begin
        w_crc_step = {w_crc_step[WORD_SIZE-2:0], 1'b0};
      end
      w_shift_step = {w_shift_step[WORD_SIZE-2:0], 1'b0};
    end
  end

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_crc_nxt   = r_crc;
    w_shift_nxt = r_shift;
    w_poly_nxt  = r_poly;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_ovr_nxt   = r_ovr;

    if (crc_init) begin
      // Reseed wins; a simultaneous write starts cleanly from the seed.
      w_crc_nxt   = INIT_VALUE;
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_done_nxt  = 1'b0;
      w_ovr_nxt   = 1'b0;
      if (data_wen) begin
        w_shift_nxt = data_in;
        w_poly_nxt  = crc_poly;
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (data_wen) begin
            w_shift_nxt = data_in;
            w_poly_nxt  = crc_poly;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b0;
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          w_crc_nxt   = w_crc_step;
          w_shift_nxt = w_shift_step;
          w_cnt_nxt   = r_cnt + 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end
          if (data_wen) begin
            w_ovr_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin : p_regs
    if (!nRST) begin
      r_state <= S_IDLE;
      r_crc   <= INIT_VALUE;
      r_shift <= '0;
      r_poly  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_crc   <= w_crc_nxt;
      r_shift <= w_shift_nxt;
      r_poly  <= w_poly_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  assign crc_out    = r_crc;
  assign crc_status = {{(WORD_SIZE-3){1'b0}}, r_ovr, r_done, (r_state == S_RUN)};

endmodule
`default_nettype wire

// File: tb/tb_poli_crc_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_poli_crc_engine
// Description : Directed bench for poli_crc_engine; four instances cover seed
//               0 / 0xFFFFFFFF and 1 / 8 bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poli_crc_engine;

  localparam int          c_NDUT = 4;
  localparam logic [31:0] c_P    = 32'h04C1_1DB7;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        crc_init   [c_NDUT];
  logic        data_wen   [c_NDUT];
  logic [31:0] crc_poly   [c_NDUT];
  logic [31:0] data_in    [c_NDUT];
  logic [31:0] crc_out    [c_NDUT];
  logic [31:0] crc_status [c_NDUT];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  // 0: seed FFFFFFFF/1b, 1: seed 0/1b, 2: seed FFFFFFFF/8b, 3: seed 0/8b
  poli_crc_engine #(.WORD_SIZE(32), .INIT_VALUE(32'hFFFF_FFFF), .BITS_PER_CYCLE(1)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .crc_init(crc_init[0]), .crc_poly(crc_poly[0]),
    .data_wen(data_wen[0]), .data_in(data_in[0]), .crc_out(crc_out[0]), .crc_status(crc_status[0]));
  poli_crc_engine #(.WORD_SIZE(32), .INIT_VALUE(32'h0000_0000), .BITS_PER_CYCLE(1)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .crc_init(crc_init[1]), .crc_poly(crc_poly[1]),
    .data_wen(data_wen[1]), .data_in(data_in[1]), .crc_out(crc_out[1]), .crc_status(crc_status[1]));
  poli_crc_engine #(.WORD_SIZE(32), .INIT_VALUE(32'hFFFF_FFFF), .BITS_PER_CYCLE(8)) u_dut2 (
    .CLK(CLK), .nRST(nRST), .crc_init(crc_init[2]), .crc_poly(crc_poly[2]),
    .data_wen(data_wen[2]), .data_in(data_in[2]), .crc_out(crc_out[2]), .crc_status(crc_status[2]));
  poli_crc_engine #(.WORD_SIZE(32), .INIT_VALUE(32'h0000_0000), .BITS_PER_CYCLE(8)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .crc_init(crc_init[3]), .crc_poly(crc_poly[3]),
    .data_wen(data_wen[3]), .data_in(data_in[3]), .crc_out(crc_out[3]), .crc_status(crc_status[3]));

  typedef struct {
    int          dut;
    bit          do_init;
    logic [31:0] poly;
    logic [31:0] data;
    logic [31:0] exp_crc;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int lat(input int d);
    return (d >= 2) ? 4 : 32;
  endfunction

  task automatic pulse_init(input int d);
    crc_init[d] = 1'b1;
    tick();
    crc_init[d] = 1'b0;
  endtask

  task automatic write(input int d, input logic [31:0] data, input logic [31:0] poly);
    data_in[d]  = data;
    crc_poly[d] = poly;
    data_wen[d] = 1'b1;
    tick();
    data_wen[d] = 1'b0;
  endtask

  // Counts clocks until BUSY drops, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(input int d, output int cyc);
    cyc = 0;
    while (crc_status[d][0] && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;

    vecs[0]  = '{1, 1'b1, c_P,          32'h0000_0001, c_P};
    vecs[1]  = '{1, 1'b1, c_P,          32'h0000_0002, 32'h0982_3B6E};
    vecs[2]  = '{1, 1'b1, c_P,          32'h0000_0003, 32'h0D43_26D9};
    vecs[3]  = '{1, 1'b1, c_P,          32'h0000_0040, 32'h3486_7077};
    vecs[4]  = '{1, 1'b0, c_P,          32'h3486_7077, 32'h0000_0000};
    vecs[5]  = '{1, 1'b1, 32'h1EDC_6F41, 32'h0000_0001, 32'h1EDC_6F41};
    vecs[6]  = '{1, 1'b1, 32'h8000_0001, 32'h0000_0002, 32'h8000_0003};
    vecs[7]  = '{0, 1'b1, c_P,          32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{0, 1'b1, c_P,          32'hFFFF_FFFE, c_P};
    vecs[9]  = '{0, 1'b0, c_P,          c_P,           32'h0000_0000};
    vecs[10] = '{3, 1'b1, c_P,          32'h0000_0001, c_P};
    vecs[11] = '{3, 1'b1, c_P,          32'h0000_0002, 32'h0982_3B6E};
    vecs[12] = '{2, 1'b1, c_P,          32'hFFFF_FFFF, 32'h0000_0000};
    vecs[13] = '{2, 1'b1, c_P,          32'hFFFF_FFFD, 32'h0982_3B6E};
    vecs[14] = '{3, 1'b1, 32'h8000_0001, 32'h0000_0002, 32'h8000_0003};

    for (int d = 0; d < c_NDUT; d++) begin
      crc_init[d] = 1'b0;
      data_wen[d] = 1'b0;
      crc_poly[d] = c_P;
      data_in[d]  = '0;
    end
    nRST = 1'b0;
    repeat (3) tick();
    check("reset_crc0",    crc_out[0],    32'hFFFF_FFFF);
    check("reset_crc1",    crc_out[1],    32'h0000_0000);
    check("reset_crc2",    crc_out[2],    32'hFFFF_FFFF);
    check("reset_status0", crc_status[0], 32'h0);
    check("reset_status3", crc_status[3], 32'h0);
    nRST = 1'b1;
    tick();

    for (int v = 0; v < 15; v++) begin
      if (vecs[v].do_init) pulse_init(vecs[v].dut);
      write(vecs[v].dut, vecs[v].data, vecs[v].poly);
      wait_done(vecs[v].dut, cyc);
      check($sformatf("vec%0d_latency", v), 32'(cyc), 32'(lat(vecs[v].dut)));
      check($sformatf("vec%0d_crc", v), crc_out[vecs[v].dut], vecs[v].exp_crc);
      check($sformatf("vec%0d_status", v), crc_status[vecs[v].dut], 32'h2);
    end

    // Overrun plus poly change mid-RUN: snapshot poly and original word survive.
    pulse_init(0);
    write(0, 32'hFFFF_FFFE, c_P);
    repeat (4) tick();
    write(0, 32'h0000_0002, 32'h1EDC_6F41);
    check("ovr_busy_during", crc_status[0], 32'h1 | 32'h4);
    wait_done(0, cyc);
    check("ovr_crc", crc_out[0], c_P);
    check("ovr_status", crc_status[0], 32'h6);
    pulse_init(0);
    check("ovr_init_status", crc_status[0], 32'h0);
    check("ovr_init_crc", crc_out[0], 32'hFFFF_FFFF);

    // Back-to-back: next word issued the first cycle BUSY reads low.
    pulse_init(1);
    write(1, 32'h0000_0001, c_P);
    wait_done(1, cyc);
    check("b2b_first_crc", crc_out[1], c_P);
    write(1, c_P, c_P);
    check("b2b_accepted", crc_status[1], 32'h1);
    wait_done(1, cyc);
    check("b2b_latency", 32'(cyc), 32'd32);
    check("b2b_crc", crc_out[1], 32'h0);
    check("b2b_status", crc_status[1], 32'h2);

    // crc_init together with data_wen during RUN (8 bits/cycle).
    pulse_init(2);
    write(2, 32'h0000_0001, c_P);
    tick();
    data_in[2]  = 32'hFFFF_FFFE;
    crc_init[2] = 1'b1;
    data_wen[2] = 1'b1;
    tick();
    crc_init[2] = 1'b0;
    data_wen[2] = 1'b0;
    check("combo_run_reseed", crc_out[2], 32'hFFFF_FFFF);
    check("combo_run_status", crc_status[2], 32'h1);
    wait_done(2, cyc);
    check("combo_run_latency", 32'(cyc), 32'd4);
    check("combo_run_crc", crc_out[2], c_P);
    check("combo_run_done", crc_status[2], 32'h2);

    // Overrun on the 8-bit engine, then crc_init+data_wen in IDLE clears it.
    pulse_init(3);
    write(3, 32'h0000_0001, c_P);
    tick();
    write(3, 32'h0000_0002, c_P);
    wait_done(3, cyc);
    check("ovr8_crc", crc_out[3], c_P);
    check("ovr8_status", crc_status[3], 32'h6);
    data_in[3]  = 32'h0000_0002;
    crc_init[3] = 1'b1;
    data_wen[3] = 1'b1;
    tick();
    crc_init[3] = 1'b0;
    data_wen[3] = 1'b0;
    check("combo_idle_status", crc_status[3], 32'h1);
    wait_done(3, cyc);
    check("combo_idle_crc", crc_out[3], 32'h0982_3B6E);
    check("combo_idle_done", crc_status[3], 32'h2);

    // Asynchronous reset at RUN cycle 10.
    pulse_init(0);
    write(0, 32'h0000_0001, c_P);
    repeat (9) tick();
    check("pre_rst_busy", crc_status[0], 32'h1);
    #2 nRST = 1'b0;
    #1;
    check("async_rst_crc", crc_out[0], 32'hFFFF_FFFF);
    check("async_rst_status", crc_status[0], 32'h0);
    check("async_rst_crc1", crc_out[1], 32'h0);
    tick();
    nRST = 1'b1;
    repeat (2) tick();
    check("post_rst_idle", crc_status[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
